// File: rtl/uart_axil_arbiter_if.sv
// rtl/uart_axil_arbiter_if.sv - AXI4-Lite bus between the arbiter (master) and the myipUART register bank (slave)
//
// Channels: AW (awaddr/awprot/awvalid/awready), W (wdata/wstrb/wvalid/wready),
// B (bresp/bvalid/bready), AR (araddr/arprot/arvalid/arready),
// R (rdata/rresp/rvalid/rready). 32-bit address and data.
// Modports: master (arbiter side), slave (register bank side).
interface uart_axil_arbiter_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/uart_axil_arbiter.sv
// rtl/uart_axil_arbiter.sv - round-robin arbiter sequencing single-word requests onto one AXI4-Lite master
//
// Ports:
//   ACLK, ARESET         clock, synchronous active-high reset
//   req_valid/req_ready  per-requester request handshake (req_ready one-hot, combinational)
//   req_we/addr/wdata    per-requester request fields (packed, 4/32 bits per requester)
//   resp_valid           one-cycle completion pulse to the owning requester
//   resp_rdata/code      read data (0 for writes) and AXI response code
//   m_axi                AXI4-Lite master port, one transaction outstanding at a time
// Optional feature: define UART_ARB_TIMEOUT_EN to abort a stuck transaction
// after TIMEOUT_CYCLES busy cycles with resp_code 2'b11.
module uart_axil_arbiter #(
    parameter int          N_REQ          = 2,
    parameter logic [31:0] BASE_ADDR      = 32'h43C0_0000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ-1:0]     req_we,
    input  logic [4*N_REQ-1:0]   req_addr,
    input  logic [32*N_REQ-1:0]  req_wdata,
    output logic [N_REQ-1:0]     resp_valid,
    output logic [31:0]          resp_rdata,
    output logic [1:0]           resp_code,
    uart_axil_arbiter_if.master  m_axi
);
    localparam int IDX_W = (N_REQ > 2) ? 2 : 1;

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WB, S_RA, S_RD, S_RESP} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] last_grant, owner, grant_idx, cand;
    logic             grant_found, accept;
    logic [31:0]      addr_q, wdata_q, rdata_q;
    logic [1:0]       code_q;
    logic             aw_done, w_done;
    logic             aw_hs, w_hs, timeout;

    assign aw_hs  = m_axi.awvalid && m_axi.awready;
    assign w_hs   = m_axi.wvalid && m_axi.wready;
    assign accept = (state == S_IDLE) && grant_found;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Held at zero while idle or responding, so it counts busy cycles only.
    always_ff @(posedge ACLK) begin
        if (ARESET || state == S_IDLE || state == S_RESP)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + TMO_W'(1);
    end

    assign timeout = (state != S_IDLE) && (state != S_RESP) &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // Round-robin search beginning one past the previous grant.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % N_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state      <= S_IDLE;
            last_grant <= IDX_W'(N_REQ - 1);
            owner      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            code_q     <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                last_grant <= grant_idx;
                owner      <= grant_idx;
                addr_q     <= {BASE_ADDR[31:4], req_addr[int'(grant_idx)*4+2 +: 2], 2'b00};
                wdata_q    <= req_wdata[int'(grant_idx)*32 +: 32];
                aw_done    <= 1'b0;
                w_done     <= 1'b0;
            end
            if (aw_hs)
                aw_done <= 1'b1;
            if (w_hs)
                w_done <= 1'b1;
            if (state == S_WB && m_axi.bvalid) begin
                code_q  <= m_axi.bresp;
                rdata_q <= '0;
            end
            if (state == S_RD && m_axi.rvalid) begin
                code_q  <= m_axi.rresp;
                rdata_q <= m_axi.rdata;
            end
            if (timeout) begin
                code_q  <= 2'b11;
                rdata_q <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = req_we[grant_idx] ? S_WR : S_RA;
            // AW and W may complete in either order or together.
            S_WR:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = S_WB;
            S_WB:   if (m_axi.bvalid) state_nxt = S_RESP;
            S_RA:   if (m_axi.arready) state_nxt = S_RD;
            S_RD:   if (m_axi.rvalid) state_nxt = S_RESP;
            S_RESP: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (timeout)
            state_nxt = S_RESP;
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        if (accept)
            req_ready[grant_idx] = 1'b1;
        if (state == S_RESP)
            resp_valid[owner] = 1'b1;
        m_axi.awaddr  = addr_q;
        m_axi.awprot  = 3'b000;
        m_axi.awvalid = (state == S_WR) && !aw_done;
        m_axi.wdata   = wdata_q;
        m_axi.wstrb   = 4'hF;
        m_axi.wvalid  = (state == S_WR) && !w_done;
        m_axi.bready  = (state == S_WB);
        m_axi.araddr  = addr_q;
        m_axi.arprot  = 3'b000;
        m_axi.arvalid = (state == S_RA);
        m_axi.rready  = (state == S_RD);
    end

    assign resp_rdata = rdata_q;
    assign resp_code  = code_q;
endmodule

// File: tb/tb_uart_axil_arbiter.sv
// tb/tb_uart_axil_arbiter.sv - scoreboard bench for uart_axil_arbiter with a behavioural register-bank slave
module tb_uart_axil_arbiter;
    localparam int N = 2;

    logic            ACLK;
    logic            ARESET;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_we;
    logic [4*N-1:0]  req_addr;
    logic [32*N-1:0] req_wdata;
    logic [N-1:0]    resp_valid;
    logic [31:0]     resp_rdata;
    logic [1:0]      resp_code;

    uart_axil_arbiter_if bus();

    uart_axil_arbiter #(.N_REQ(N), .BASE_ADDR(32'h43C0_0000), .TIMEOUT_CYCLES(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_code(resp_code),
        .m_axi(bus)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Behavioural slave: four-word register bank with knobs for delays and errors.
    logic [31:0] mem [4];
    int          aw_cnt, w_cnt;
    int          aw_delay = 0, w_delay = 0;
    bit          b_block = 0, ar_block = 0, err_en = 0;
    logic        have_aw, have_w, bv, rv;
    logic [1:0]  aw_idx;
    logic [31:0] w_dat, rd_dat, last_awaddr, last_araddr;
    logic [1:0]  rd_resp;
    int          aw_hs_n, w_hs_n, b_hs_n;

    assign bus.awready = bus.awvalid && (aw_cnt >= aw_delay);
    assign bus.wready  = bus.wvalid && (w_cnt >= w_delay);
    assign bus.bvalid  = bv;
    assign bus.bresp   = 2'b00;
    assign bus.arready = bus.arvalid && !ar_block && !rv;
    assign bus.rvalid  = rv;
    assign bus.rdata   = rd_dat;
    assign bus.rresp   = rd_resp;

    always @(posedge ACLK) begin
        logic       aw_ok, w_ok;
        logic [1:0] idx;
        logic [31:0] dat;
        if (ARESET) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
            aw_cnt <= 0; w_cnt <= 0; have_aw <= 0; have_w <= 0; bv <= 0; rv <= 0;
            aw_idx <= '0; w_dat <= '0; rd_dat <= '0; rd_resp <= '0;
        end else begin
            aw_ok = have_aw || (bus.awvalid && bus.awready);
            w_ok  = have_w || (bus.wvalid && bus.wready);
            idx   = have_aw ? aw_idx : bus.awaddr[3:2];
            dat   = have_w ? w_dat : bus.wdata;
            if (bus.awvalid && bus.awready) begin
                have_aw <= 1; aw_idx <= bus.awaddr[3:2]; aw_cnt <= 0;
                aw_hs_n <= aw_hs_n + 1; last_awaddr <= bus.awaddr;
            end else if (bus.awvalid) aw_cnt <= aw_cnt + 1;
            if (bus.wvalid && bus.wready) begin
                have_w <= 1; w_dat <= bus.wdata; w_cnt <= 0; w_hs_n <= w_hs_n + 1;
            end else if (bus.wvalid) w_cnt <= w_cnt + 1;
            if (bv && bus.bready) begin bv <= 0; b_hs_n <= b_hs_n + 1; end
            if (aw_ok && w_ok && !b_block && !bv) begin
                mem[idx] <= dat; bv <= 1; have_aw <= 0; have_w <= 0;
            end
            if (bus.arvalid && bus.arready) begin
                rv <= 1; last_araddr <= bus.araddr;
                if (err_en && bus.araddr[3:2] == 2'd3) begin rd_dat <= '0; rd_resp <= 2'b10; end
                else begin rd_dat <= mem[bus.araddr[3:2]]; rd_resp <= 2'b00; end
            end
            if (rv && bus.rready) rv <= 0;
        end
    end

    // Scoreboard queues, filled by stimulus, drained by the monitors.
    typedef struct { int idx; logic [31:0] rdata; logic [1:0] code; } exp_t;
    exp_t exp_q[$];
    int   grant_q[$];

    task automatic expect_resp(input int idx, input logic [31:0] d, input logic [1:0] c);
        exp_t e;
        e.idx = idx; e.rdata = d; e.code = c;
        exp_q.push_back(e);
    endtask

    always @(negedge ACLK) begin
        exp_t e;
        if (!ARESET && resp_valid != '0) begin
            if (exp_q.size() == 0) check("resp_unexpected", 32'(resp_valid), 32'd0);
            else begin
                e = exp_q.pop_front();
                check("resp_owner", 32'(resp_valid), 32'(1 << e.idx));
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_code", 32'(resp_code), 32'(e.code));
            end
        end
    end

    always @(negedge ACLK) begin
        logic [N-1:0] acc;
        int g;
        #2;
        acc = req_valid & req_ready;
        if (!ARESET && acc != '0) begin
            if (grant_q.size() == 0) check("grant_unexpected", 32'(acc), 32'd0);
            else begin
                g = grant_q.pop_front();
                check("grant", 32'(acc), 32'(1 << g));
            end
        end
    end

    task automatic issue(input int idx, input bit we, input logic [3:0] a, input logic [31:0] d);
        int n = 0;
        req_we[idx] = we;
        req_addr[idx*4 +: 4] = a;
        req_wdata[idx*32 +: 32] = d;
        req_valid[idx] = 1'b1;
        #1;
        while (!req_ready[idx] && n < 300) begin
            @(negedge ACLK); #1; n++;
        end
        check("accepted", 32'(req_ready[idx]), 32'd1);
        @(posedge ACLK); #1;
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_resp(input int idx, input int exp_lat);
        int n = 0;
        do begin
            @(negedge ACLK); n++;
        end while (!resp_valid[idx] && n < 300);
        check("resp_seen", 32'(resp_valid[idx]), 32'd1);
        if (exp_lat > 0) check("latency", 32'(n), 32'(exp_lat));
    endtask

    task automatic pulse_reset();
        @(negedge ACLK); ARESET = 1'b1;
        @(posedge ACLK); #1; ARESET = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        check({tag, "_resp_code"}, 32'(resp_code), 32'd0);
        check({tag, "_axi_valids"}, 32'({bus.awvalid, bus.wvalid, bus.arvalid}), 32'd0);
        check({tag, "_axi_readys"}, 32'({bus.bready, bus.rready}), 32'd0);
        check({tag, "_awaddr"}, bus.awaddr, 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || grant_q.size() != 0) && n < 300) begin
            @(negedge ACLK); n++;
        end
        check("resp_q_drained", 32'(exp_q.size()), 32'd0);
        check("grant_q_drained", 32'(grant_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench watchdog");
    end

    initial begin
        int a0, w0, b0;
        ARESET = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        aw_hs_n = 0; w_hs_n = 0; b_hs_n = 0; last_awaddr = '0; last_araddr = '0;
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;
        @(negedge ACLK);
        check_reset_outputs("reset");

        // Write then read back on requester 0 with an always-ready slave.
        grant_q.push_back(0); expect_resp(0, 32'h0, 2'b00);
        issue(0, 1'b1, 4'h0, 32'h0101_FFFF);
        wait_resp(0, 3);
        check("awaddr_off0", last_awaddr, 32'h43C0_0000);
        grant_q.push_back(0); expect_resp(0, 32'h0101_FFFF, 2'b00);
        issue(0, 1'b0, 4'h0, 32'h0);
        wait_resp(0, 3);
        drain();

        // Both requesters continuously asserting from reset.
        pulse_reset();
        grant_q.push_back(0); grant_q.push_back(1); grant_q.push_back(0); grant_q.push_back(1);
        expect_resp(0, 32'h0, 2'b00); expect_resp(1, 32'h0, 2'b00);
        expect_resp(0, 32'h0, 2'b00); expect_resp(1, 32'h0, 2'b00);
        fork
            begin
                issue(0, 1'b1, 4'h4, 32'hABCD_0001);
                issue(0, 1'b1, 4'h4, 32'hABCD_0001);
            end
            begin
                issue(1, 1'b1, 4'h8, 32'hDEAD_0011);
                issue(1, 1'b1, 4'h8, 32'hDEAD_0011);
            end
        join
        drain();
        grant_q.push_back(0); expect_resp(0, 32'hABCD_0001, 2'b00);
        issue(0, 1'b0, 4'h4, 32'h0);
        wait_resp(0, 3);
        grant_q.push_back(1); expect_resp(1, 32'hDEAD_0011, 2'b00);
        issue(1, 1'b0, 4'h8, 32'h0);
        wait_resp(1, 3);
        drain();

        // W accepted three cycles before AW.
        aw_delay = 3; w_delay = 0;
        a0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
        grant_q.push_back(1); expect_resp(1, 32'h0, 2'b00);
        issue(1, 1'b1, 4'hC, 32'h5A5A_1234);
        @(negedge ACLK);
        @(negedge ACLK);
        check("wvalid_dropped", 32'(bus.wvalid), 32'd0);
        check("awvalid_held", 32'(bus.awvalid), 32'd1);
        wait_resp(1, 0);
        drain();
        check("aw_handshakes", 32'(aw_hs_n - a0), 32'd1);
        check("w_handshakes", 32'(w_hs_n - w0), 32'd1);
        check("b_handshakes", 32'(b_hs_n - b0), 32'd1);
        check("awaddr_offC", last_awaddr, 32'h43C0_000C);
        aw_delay = 0;

        // SLVERR on read of 0xC, then the next request is served normally.
        err_en = 1;
        grant_q.push_back(0); expect_resp(0, 32'h0, 2'b10);
        issue(0, 1'b0, 4'hC, 32'h0);
        wait_resp(0, 3);
        check("araddr_offC", last_araddr, 32'h43C0_000C);
        err_en = 0;
        grant_q.push_back(1); expect_resp(1, 32'h5A5A_1234, 2'b00);
        issue(1, 1'b0, 4'hC, 32'h0);
        wait_resp(1, 3);
        drain();

        // Reset while waiting in WB; transaction is abandoned.
        b_block = 1;
        grant_q.push_back(0);
        issue(0, 1'b1, 4'h0, 32'h1111_2222);
        @(negedge ACLK);
        @(negedge ACLK);
        check("in_wb_bready", 32'(bus.bready), 32'd1);
        ARESET = 1'b1;
        @(posedge ACLK); #1; ARESET = 1'b0;
        @(negedge ACLK);
        check_reset_outputs("midreset");
        b_block = 0;
        grant_q.push_back(0); grant_q.push_back(1);
        expect_resp(0, 32'h0, 2'b00); expect_resp(1, 32'h0, 2'b00);
        fork
            issue(0, 1'b0, 4'h0, 32'h0);
            issue(1, 1'b0, 4'h4, 32'h0);
        join
        drain();

`ifdef UART_ARB_TIMEOUT_EN
        // Slave never accepts AR; watchdog aborts after 16 busy cycles.
        ar_block = 1;
        grant_q.push_back(0); expect_resp(0, 32'h0, 2'b11);
        issue(0, 1'b0, 4'h4, 32'h0);
        wait_resp(0, 17);
        drain();
        ar_block = 0;
        pulse_reset();
`endif

        repeat (3) @(negedge ACLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
